// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding and default width for the SAR search block.
package sar_pkg;
  localparam int SAR_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} sar_state_e;
endpackage

// File: rtl/sar_search.sv
// sar_search: successive-approximation search driving an external comparator,
// one trial per cycle, with early exit on equality and abort on illegal codes.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             err
);
  localparam int IW = $clog2(WIDTH);
  sar_state_e state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d, result_q, result_d, g;
  logic [IW-1:0] idx_q, idx_d;
  logic exact_q, exact_d, err_q, err_d, one_hot;
  // odd count of set bits, excluding all three, means exactly one set
  assign one_hot = (cmp_lt ^ cmp_gt ^ cmp_eq) & ~(cmp_lt & cmp_gt & cmp_eq);
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    idx_d    = idx_q;
    result_d = result_q;
    exact_d  = exact_q;
    err_d    = err_q;
    g        = guess_q;
    if (state_q == IDLE && start) begin
      guess_d = {1'b1, {(WIDTH-1){1'b0}}};
      idx_d   = IW'(WIDTH-1);
      exact_d = 1'b0;
      err_d   = 1'b0;
      state_d = SEARCH;
    end else if (state_q == SEARCH) begin
      if (!one_hot) begin
        result_d = guess_q;
        err_d    = 1'b1;
        state_d  = DONE;
      end else if (cmp_eq) begin
        result_d = guess_q;
        exact_d  = 1'b1;
        state_d  = DONE;
      end else begin
        g[idx_q] = g[idx_q] & ~cmp_lt;
        if (idx_q != '0) begin
          g[idx_q - IW'(1)] = 1'b1;
          idx_d = idx_q - IW'(1);
        end else begin
          result_d = g;
          exact_d  = 1'b0;
          state_d  = DONE;
        end
        guess_d = g;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      idx_q    <= '0;
      result_q <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end
  assign guess  = guess_q;
  assign result = result_q;
  assign exact  = exact_q;
  assign err    = err_q;
  assign busy   = state_q == SEARCH;
  assign done   = state_q == DONE;
endmodule
